// File: rtl/mp2_buffer_arbiter.sv
// Round-robin arbiter sharing the const ROM, sample RAM and multiplier among DBS, BDD and Synth.
// The grant is held while the owner keeps Req high, then TURN_CYC dead cycles pass before re-arbitration.
module mp2_buffer_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MULT_W   = 18,
  parameter int TURN_CYC = 1
) (
  input  logic              audio_decoder_clock,
  input  logic              reset,
  input  logic              Req_0_I,
  output logic              Grant_0_O,
  input  logic              ROM_En_0_I,
  input  logic [ADDR_W-1:0] ROM_Addr_0_I,
  input  logic [ADDR_W-1:0] RAM_Addr_0_I,
  input  logic              RAM_Wen_0_I,
  input  logic [DATA_W-1:0] RAM_Data_0_I,
  input  logic [MULT_W-1:0] Mult_OP0_0_I,
  input  logic [MULT_W-1:0] Mult_OP1_0_I,
  input  logic              Req_1_I,
  output logic              Grant_1_O,
  input  logic              ROM_En_1_I,
  input  logic [ADDR_W-1:0] ROM_Addr_1_I,
  input  logic [ADDR_W-1:0] RAM_Addr_1_I,
  input  logic              RAM_Wen_1_I,
  input  logic [DATA_W-1:0] RAM_Data_1_I,
  input  logic [MULT_W-1:0] Mult_OP0_1_I,
  input  logic [MULT_W-1:0] Mult_OP1_1_I,
  input  logic              Req_2_I,
  output logic              Grant_2_O,
  input  logic              ROM_En_2_I,
  input  logic [ADDR_W-1:0] ROM_Addr_2_I,
  input  logic [ADDR_W-1:0] RAM_Addr_2_I,
  input  logic              RAM_Wen_2_I,
  input  logic [DATA_W-1:0] RAM_Data_2_I,
  input  logic [MULT_W-1:0] Mult_OP0_2_I,
  input  logic [MULT_W-1:0] Mult_OP1_2_I,
  output logic              ROM_En_O,
  output logic [ADDR_W-1:0] ROM_Addr_O,
  output logic [ADDR_W-1:0] RAM_Addr_O,
  output logic              RAM_Wen_O,
  output logic [DATA_W-1:0] RAM_Data_O,
  output logic [MULT_W-1:0] Mult_OP0_O,
  output logic [MULT_W-1:0] Mult_OP1_O,
  output logic [1:0]        Owner_O,
  output logic              Busy_O,
  output logic              Illegal_Wr_O
);

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] turn_cnt, turn_cnt_nxt;
  logic [1:0] cand1, cand2;
  logic [3:0] req;
  logic [2:0] wen;
  logic [2:0] grant;
  logic       illegal;

  assign req = {1'b0, Req_2_I, Req_1_I, Req_0_I};
  assign wen = {RAM_Wen_2_I, RAM_Wen_1_I, RAM_Wen_0_I};

  // Search order starts just after the last owner and ends on it.
  assign cand1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
  assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;

  always_ff @(posedge audio_decoder_clock) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last     <= 2'd2;
      turn_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      turn_cnt <= turn_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last;
    turn_cnt_nxt = turn_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWNED;
          if (req[cand1])      owner_nxt = cand1;
          else if (req[cand2]) owner_nxt = cand2;
          else                 owner_nxt = last;
          last_nxt = owner_nxt;
        end
      end
      OWNED: begin
        if (!req[owner]) begin
          state_nxt    = TURN;
          turn_cnt_nxt = 2'(TURN_CYC - 1);
        end
      end
      TURN: begin
        if (turn_cnt == 2'd0) state_nxt = IDLE;
        else                  turn_cnt_nxt = turn_cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy_O    = (state == OWNED);
  assign Owner_O   = Busy_O ? owner : 2'd3;
  assign grant     = Busy_O ? (3'b001 << owner) : 3'b000;
  assign Grant_0_O = grant[0];
  assign Grant_1_O = grant[1];
  assign Grant_2_O = grant[2];

  // Any requester writing without holding the bus poisons the flag until reset.
  always_ff @(posedge audio_decoder_clock) begin
    if (reset)                           illegal <= 1'b0;
    else if (|(req[2:0] & wen & ~grant)) illegal <= 1'b1;
  end
  assign Illegal_Wr_O = illegal;

  always_comb begin
    ROM_En_O   = 1'b0;
    ROM_Addr_O = '0;
    RAM_Addr_O = '0;
    RAM_Wen_O  = 1'b0;
    RAM_Data_O = '0;
    Mult_OP0_O = '0;
    Mult_OP1_O = '0;
    case (grant)
      3'b001: begin
        ROM_En_O = ROM_En_0_I;  ROM_Addr_O = ROM_Addr_0_I; RAM_Addr_O = RAM_Addr_0_I;
        RAM_Wen_O = RAM_Wen_0_I; RAM_Data_O = RAM_Data_0_I;
        Mult_OP0_O = Mult_OP0_0_I; Mult_OP1_O = Mult_OP1_0_I;
      end
      3'b010: begin
        ROM_En_O = ROM_En_1_I;  ROM_Addr_O = ROM_Addr_1_I; RAM_Addr_O = RAM_Addr_1_I;
        RAM_Wen_O = RAM_Wen_1_I; RAM_Data_O = RAM_Data_1_I;
        Mult_OP0_O = Mult_OP0_1_I; Mult_OP1_O = Mult_OP1_1_I;
      end
      3'b100: begin
        ROM_En_O = ROM_En_2_I;  ROM_Addr_O = ROM_Addr_2_I; RAM_Addr_O = RAM_Addr_2_I;
        RAM_Wen_O = RAM_Wen_2_I; RAM_Data_O = RAM_Data_2_I;
        Mult_OP0_O = Mult_OP0_2_I; Mult_OP1_O = Mult_OP1_2_I;
      end
      default: ;
    endcase
  end

endmodule
